// File: rtl/sid_spi_pkg.sv
// Shared types and constants for the SID voice-register SPI write path.
// Frame layout, register map and the master's state encoding.
package sid_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    localparam logic [ADDR_W-1:0] REG_FREQ_LO  = 8'h00;
    localparam logic [ADDR_W-1:0] REG_FREQ_HI  = 8'h01;
    localparam logic [ADDR_W-1:0] REG_DUR_LO   = 8'h02;
    localparam logic [ADDR_W-1:0] REG_DUR_HI   = 8'h03;
    localparam logic [ADDR_W-1:0] REG_ATTACK   = 8'h04;
    localparam logic [ADDR_W-1:0] REG_SUSTAIN  = 8'h05;
    localparam logic [ADDR_W-1:0] REG_WAVEFORM = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LO,
        HI,
        HOLD,
        GAP
    } state_e;

endpackage

// File: rtl/spi_reg_master_if.sv
// Request-side bundle of the SPI register master: write handshake
// plus the busy / frame_done status flags.
interface spi_reg_master_if;
    import sid_spi_pkg::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              busy;
    logic              frame_done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, busy, frame_done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, busy, frame_done
    );

endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 master writing {addr,data} frames into the SID register bank.
// Every edge is held for whole clk cycles so a synchronising slave sees it.
module spi_reg_master
    import sid_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_reg_master_if.slave  req,
    output logic             spi_clk_o,
    output logic             spi_cs_n_o,
    output logic             spi_mosi_o
);

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);

    // Phase counter is 8 bits wide; out-of-range values would wrap it.
    if (CLK_DIV < 4 || CLK_DIV > 256) begin : g_bad_div
        $error("CLK_DIV must be in 4..256");
    end
    if (CS_SETUP < 1 || CS_SETUP > 256) begin : g_bad_setup
        $error("CS_SETUP must be in 1..256");
    end
    if (CS_HOLD < 1 || CS_HOLD > 256) begin : g_bad_hold
        $error("CS_HOLD must be in 1..256");
    end
    if (CS_GAP < 1 || CS_GAP > 256) begin : g_bad_gap
        $error("CS_GAP must be in 1..256");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         idx_q;
    // Bit 15 goes straight to mosi at accept, so only 15 bits are kept.
    logic [FRAME_W-2:0] shift_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               sclk_q;
    logic               cs_n_q;
    logic               mosi_q;

    assign req.req_ready  = ready_q;
    assign req.busy       = busy_q;
    assign req.frame_done = done_q;
    assign spi_clk_o      = sclk_q;
    assign spi_cs_n_o     = cs_n_q;
    assign spi_mosi_o     = mosi_q;

    // Frame sequencer: all pins and status flags are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'hF;
            shift_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && req.req_valid) begin
                        shift_q <= {req.req_addr[ADDR_W-2:0], req.req_data};
                        mosi_q  <= req.req_addr[ADDR_W-1];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        idx_q   <= 4'hF;
                        cnt_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= DIV_LD;
                        state_q <= LO;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                LO: begin
                    if (cnt_q == '0) begin
                        sclk_q  <= 1'b1;
                        cnt_q   <= DIV_LD;
                        state_q <= HI;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HI: begin
                    if (cnt_q == '0) begin
                        sclk_q <= 1'b0;
                        if (idx_q == 4'd0) begin
                            cnt_q   <= HOLD_LD;
                            state_q <= HOLD;
                        end else begin
                            // mosi moves on the same edge sclk falls.
                            idx_q   <= idx_q - 1'b1;
                            mosi_q  <= shift_q[FRAME_W-2];
                            shift_q <= {shift_q[FRAME_W-3:0], 1'b0};
                            cnt_q   <= DIV_LD;
                            state_q <= LO;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= GAP_LD;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
